// File: rtl/uart_link_ctrl_pkg.sv
// rtl/uart_link_ctrl_pkg.sv - shared frame constants, state encodings and checksum helper
package uart_link_ctrl_pkg;

  localparam int         FRAME_LEN = 3;
  localparam logic [7:0] ACK_CODE  = 8'h06;
  localparam logic [7:0] NACK_CODE = 8'h15;

  typedef enum logic [1:0] {
    P_CMD = 2'd0,
    P_ARG = 2'd1,
    P_CHK = 2'(FRAME_LEN - 1)
  } parser_state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_WAIT  = 2'd2
  } tx_state_t;

  function automatic logic [7:0] frame_checksum(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd ^ arg;
  endfunction

endpackage

// File: rtl/uart_link_ctrl_if.sv
// rtl/uart_link_ctrl_if.sv - uart_rx/uart_tx, command and response signals of the link controller
interface uart_link_ctrl_if;

  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_parity_error;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_arg;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_ready;
  logic [7:0]  err_count;

  modport master (
    input  rx_data, rx_done, rx_parity_error, tx_busy, resp_valid, resp_data,
    output tx_data, tx_start, cmd_valid, cmd_code, cmd_arg, resp_ready, err_count
  );

  modport slave (
    output rx_data, rx_done, rx_parity_error, tx_busy, resp_valid, resp_data,
    input  tx_data, tx_start, cmd_valid, cmd_code, cmd_arg, resp_ready, err_count
  );

endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - [CMD][ARG][CHK] frame parser with inter-byte timeout
module uart_frame_parser
  import uart_link_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 48000,
  parameter int NUM_CMDS    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_parity_error,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       ack_req,
  output logic       nack_req,
  output logic       timeout_err
);

  localparam int               CNT_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       CODE_LIMIT = 8'(NUM_CMDS);

  parser_state_t    state;
  logic [7:0]       cmd_byte;
  logic [7:0]       arg_byte;
  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= P_CMD;
      cmd_byte    <= '0;
      arg_byte    <= '0;
      idle_cnt    <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_arg     <= '0;
      ack_req     <= 1'b0;
      nack_req    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      ack_req     <= 1'b0;
      nack_req    <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_done) begin
        idle_cnt <= '0;
        // A parity error kills the frame at once, whatever byte it hit.
        if (rx_parity_error) begin
          state    <= P_CMD;
          nack_req <= 1'b1;
        end else begin
          case (state)
            P_CMD: begin
              cmd_byte <= rx_data;
              state    <= P_ARG;
            end
            P_ARG: begin
              arg_byte <= rx_data;
              state    <= P_CHK;
            end
            default: begin
              state <= P_CMD;
              if (rx_data == frame_checksum(cmd_byte, arg_byte) && cmd_byte < CODE_LIMIT) begin
                cmd_valid <= 1'b1;
                cmd_code  <= cmd_byte;
                cmd_arg   <= arg_byte;
                ack_req   <= 1'b1;
              end else begin
                nack_req <= 1'b1;
              end
            end
          endcase
        end
      end else if (state != P_CMD) begin
        if (idle_cnt == LAST_CNT) begin
          state       <= P_CMD;
          idle_cnt    <= '0;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// rtl/uart_link_ctrl.sv - command/response sequencer sharing one uart_tx between ACK/NACK and response words
module uart_link_ctrl
  import uart_link_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 48000,
  parameter int         NUM_CMDS    = 6,
  parameter logic [7:0] ACK_BYTE    = ACK_CODE,
  parameter logic [7:0] NACK_BYTE   = NACK_CODE
) (
  input logic             clk,
  input logic             reset,
  uart_link_ctrl_if.master bus
);

  tx_state_t  state;
  logic       ack_req;
  logic       nack_req;
  logic       timeout_err;
  logic       ack_pending;
  logic [7:0] ack_byte;
  logic       lsb_pending;
  logic [7:0] lsb_byte;
  logic       consume;
  logic       drop;
  logic       err_inc;
  logic       ack_pending_nxt;
  logic [7:0] ack_byte_nxt;

  uart_frame_parser #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .NUM_CMDS    (NUM_CMDS)
  ) u_parser (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (bus.rx_data),
    .rx_done         (bus.rx_done),
    .rx_parity_error (bus.rx_parity_error),
    .cmd_valid       (bus.cmd_valid),
    .cmd_code        (bus.cmd_code),
    .cmd_arg         (bus.cmd_arg),
    .ack_req         (ack_req),
    .nack_req        (nack_req),
    .timeout_err     (timeout_err)
  );

  // Single-entry answer slot: a new answer is only taken if the slot is empty or being sent now.
  always_comb begin
    consume         = (state == T_IDLE) && ack_pending && !bus.tx_busy;
    drop            = (ack_req || nack_req) && ack_pending && !consume;
    ack_pending_nxt = ack_pending;
    ack_byte_nxt    = ack_byte;
    if ((ack_req || nack_req) && !drop) begin
      ack_pending_nxt = 1'b1;
      ack_byte_nxt    = ack_req ? ACK_BYTE : NACK_BYTE;
    end else if (consume) begin
      ack_pending_nxt = 1'b0;
    end
    err_inc = nack_req || timeout_err || drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= T_IDLE;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.resp_ready <= 1'b0;
      bus.err_count  <= '0;
      ack_pending    <= 1'b0;
      ack_byte       <= '0;
      lsb_pending    <= 1'b0;
      lsb_byte       <= '0;
    end else begin
      ack_pending <= ack_pending_nxt;
      ack_byte    <= ack_byte_nxt;
      if (err_inc && bus.err_count != 8'hFF) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
      case (state)
        T_IDLE: begin
          if (consume) begin
            bus.tx_data    <= ack_byte;
            bus.tx_start   <= 1'b1;
            bus.resp_ready <= 1'b0;
            state          <= T_START;
          end else if (bus.resp_valid && bus.resp_ready) begin
            bus.tx_data    <= bus.resp_data[15:8];
            lsb_byte       <= bus.resp_data[7:0];
            lsb_pending    <= 1'b1;
            bus.tx_start   <= 1'b1;
            bus.resp_ready <= 1'b0;
            state          <= T_START;
          end else begin
            bus.resp_ready <= !ack_pending_nxt && !bus.tx_busy;
          end
        end
        T_START: begin
          if (bus.tx_busy) begin
            bus.tx_start <= 1'b0;
            state        <= T_WAIT;
          end
        end
        T_WAIT: begin
          // The LSB of a response goes out before any queued answer.
          if (!bus.tx_busy) begin
            if (lsb_pending) begin
              bus.tx_data  <= lsb_byte;
              lsb_pending  <= 1'b0;
              bus.tx_start <= 1'b1;
              state        <= T_START;
            end else begin
              bus.resp_ready <= !ack_pending_nxt;
              state          <= T_IDLE;
            end
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb/tb_uart_link_ctrl.sv - randomized self-checking bench for uart_link_ctrl against a frame-level model
module tb_uart_link_ctrl;

  localparam int         TMO  = 100;
  localparam int         NCMD = 6;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;
  localparam int         BUSY_LEN = 8;

  logic clk;
  logic reset;
  uart_link_ctrl_if bus();

  uart_link_ctrl #(.TIMEOUT_CYC(TMO), .NUM_CMDS(NCMD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] got_cmd[$];
  logic [15:0] exp_cmd[$];
  int          exp_err = 0;
  logic [7:0]  last_code = 8'h00;
  logic [7:0]  last_arg  = 8'h00;
  int          busy_cnt = 0;
  bit          watch_rr = 0;
  int          rr_high  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: takes a byte on tx_start when idle and stays busy for BUSY_LEN cycles.
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus.tx_busy = 1'b0;
    end else if (bus.tx_start) begin
      got_tx.push_back(bus.tx_data);
      busy_cnt    = BUSY_LEN;
      bus.tx_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.cmd_valid) got_cmd.push_back({bus.cmd_code, bus.cmd_arg});
    if (watch_rr && bus.resp_ready) rr_high++;
  end

  function automatic void bump_err();
    if (exp_err < 255) exp_err++;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit perr, input int gap, output logic cv);
    bus.rx_data         = d;
    bus.rx_parity_error = perr;
    bus.rx_done         = 1'b1;
    @(negedge clk);
    cv                  = bus.cmd_valid;
    bus.rx_done         = 1'b0;
    bus.rx_parity_error = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                            input int perr_idx, input int gap, input bit dropped);
    logic [7:0] bytes [3];
    logic       cv;
    bit         valid;
    int         n;
    bytes[0] = cmd;
    bytes[1] = arg;
    bytes[2] = chk;
    n  = (perr_idx >= 0) ? perr_idx + 1 : 3;
    cv = 1'b0;
    for (int i = 0; i < n; i++) send_byte(bytes[i], (i == perr_idx), gap, cv);
    valid = (perr_idx < 0) && (chk == (cmd ^ arg)) && (32'(cmd) < NCMD);
    if (valid) begin
      exp_cmd.push_back({cmd, arg});
      last_code = cmd;
      last_arg  = arg;
    end
    if (!valid || dropped) bump_err();
    if (!dropped) exp_tx.push_back(valid ? ACK : NACK);
    if (perr_idx < 0) check_eq("cmd_valid_latency", 32'(cv), 32'(valid));
  endtask

  task automatic offer_resp(input logic [15:0] w);
    int t = 0;
    bus.resp_data  = w;
    bus.resp_valid = 1'b1;
    while (!bus.resp_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("resp_handshake", 32'(bus.resp_ready), 32'd1);
    @(negedge clk);
    bus.resp_valid = 1'b0;
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic wait_idle();
    int idle = 0;
    int t    = 0;
    while (idle < 15 && t < 1000) begin
      @(negedge clk);
      t++;
      if (!bus.tx_busy && !bus.tx_start) idle++;
      else idle = 0;
    end
    check_eq("idle_reached", 32'(idle >= 15), 32'd1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    check_eq({tag, "_tx_count"}, got_tx.size(), exp_tx.size());
    n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_tx_byte"}, 32'(got_tx[i]), 32'(exp_tx[i]));
    check_eq({tag, "_cmd_count"}, got_cmd.size(), exp_cmd.size());
    n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_cmd"}, 32'(got_cmd[i]), 32'(exp_cmd[i]));
    check_eq({tag, "_err_count"}, 32'(bus.err_count), exp_err);
    check_eq({tag, "_cmd_code"}, 32'(bus.cmd_code), 32'(last_code));
    check_eq({tag, "_cmd_arg"}, 32'(bus.cmd_arg), 32'(last_arg));
    got_tx.delete();
    exp_tx.delete();
    got_cmd.delete();
    exp_cmd.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check_eq({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check_eq({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    check_eq({tag, "_cmd_code"}, 32'(bus.cmd_code), 32'd0);
    check_eq({tag, "_cmd_arg"}, 32'(bus.cmd_arg), 32'd0);
    check_eq({tag, "_resp_ready"}, 32'(bus.resp_ready), 32'd0);
    check_eq({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
  endtask

  initial begin
    logic [7:0] c, a, k;
    logic       cv;
    int         t;
    reset               = 1'b1;
    bus.rx_data         = '0;
    bus.rx_done         = 1'b0;
    bus.rx_parity_error = 1'b0;
    bus.tx_busy         = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_data       = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    send_frame(8'h02, 8'h10, 8'h12, -1, 2, 0);
    wait_idle();
    compare_all("valid");
    send_frame(8'h02, 8'h10, 8'h13, -1, 2, 0);
    wait_idle();
    compare_all("bad_chk");
    send_frame(8'h07, 8'h00, 8'h07, -1, 2, 0);
    wait_idle();
    compare_all("bad_code");
    send_frame(8'h02, 8'h10, 8'h12, 1, 2, 0);
    send_frame(8'h03, 8'h01, 8'h02, -1, 2, 0);
    wait_idle();
    compare_all("parity");

    send_byte(8'h02, 1'b0, 1, cv);
    send_byte(8'h10, 1'b0, TMO + 20, cv);
    bump_err();
    send_frame(8'h04, 8'h05, 8'h01, -1, 2, 0);
    wait_idle();
    compare_all("timeout");
    send_frame(8'h01, 8'h22, 8'h23, -1, TMO - 10, 0);
    wait_idle();
    compare_all("near_timeout");

    offer_resp(16'hABCD);
    watch_rr = 1;
    rr_high  = 0;
    send_frame(8'h02, 8'h10, 8'h12, -1, 0, 0);
    t = 0;
    while (got_tx.size() < 3 && t < 300) begin
      @(negedge clk);
      t++;
    end
    watch_rr = 0;
    check_eq("resp_ready_low", rr_high, 0);
    wait_idle();
    compare_all("resp_mid_msb");

    offer_resp(16'h1234);
    send_frame(8'h05, 8'h0A, 8'h0F, -1, 0, 0);
    send_frame(8'h01, 8'h01, 8'h01, -1, 0, 1);
    wait_idle();
    compare_all("ack_drop");

    offer_resp(16'h5A3C);
    t = 0;
    while (!bus.tx_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    reset = 1'b0;
    void'(exp_tx.pop_back());
    exp_err   = 0;
    last_code = 8'h00;
    last_arg  = 8'h00;
    wait_idle();
    compare_all("reset_mid");
    send_frame(8'h03, 8'h07, 8'h04, -1, 2, 0);
    wait_idle();
    compare_all("after_reset");

    for (int it = 0; it < 30; it++) begin
      int kind;
      int gap;
      kind = $urandom_range(0, 4);
      gap  = $urandom_range(0, 12);
      a    = 8'($urandom_range(0, 255));
      case (kind)
        0: begin
          c = 8'($urandom_range(0, NCMD - 1));
          send_frame(c, a, c ^ a, -1, gap, 0);
        end
        1: begin
          c = 8'($urandom_range(0, NCMD - 1));
          k = 8'($urandom_range(1, 255));
          send_frame(c, a, c ^ a ^ k, -1, gap, 0);
        end
        2: begin
          c = 8'($urandom_range(NCMD, 255));
          send_frame(c, a, c ^ a, -1, gap, 0);
        end
        3: begin
          c = 8'($urandom_range(0, NCMD - 1));
          send_frame(c, a, c ^ a, $urandom_range(0, 2), gap, 0);
        end
        default: offer_resp(16'($urandom_range(0, 65535)));
      endcase
      wait_idle();
      compare_all("rnd");
    end

    for (int i = 0; i < 260; i++) begin
      send_byte(8'hAA, 1'b1, 3, cv);
      bump_err();
    end
    wait_idle();
    got_tx.delete();
    exp_tx.delete();
    check_eq("err_saturated", 32'(bus.err_count), 32'd255);
    send_frame(8'h09, 8'h00, 8'h09, -1, 2, 0);
    wait_idle();
    compare_all("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
Command/response sequencer between the board logic and the existing uart_rx/uart_tx pair.
- Parses 3-byte command frames [CMD][ARG][CHK] from uart_rx and presents validated commands to the fire/ADC logic.
- Answers each frame with ACK/NACK and shares the single uart_tx between those answers and 16-bit response words (e.g. ADC readings).
- Replaces ad-hoc echo logic in board tops.

Parameters:
- TIMEOUT_CYC, 48000: inter-byte timeout in clk cycles (1 ms at 48 MHz).
- NUM_CMDS, 6: CMD codes 0..NUM_CMDS-1 are legal.
- ACK_BYTE, 8'h06: byte sent for an accepted frame.
- NACK_BYTE, 8'h15: byte sent for a rejected frame.

Ports:
- clk  in  1  system clock (48 MHz HFOSC)
- reset  in  1  synchronous, active-high
- rx_data  in  8  uart_rx data_received
- rx_done  in  1  uart_rx one-cycle byte strobe
- rx_parity_error  in  1  uart_rx parity_error, valid with rx_done
- tx_data  out  8  to uart_tx data_to_tx
- tx_start  out  1  to uart_tx start_tx
- tx_busy  in  1  from uart_tx
- cmd_valid  out  1  one-cycle pulse, valid command
- cmd_code  out  8  last valid CMD
- cmd_arg  out  8  last valid ARG
- resp_valid  in  1  response word offered
- resp_data  in  16  response word
- resp_ready  out  1  response accepted when resp_valid && resp_ready
- err_count  out  8  saturating error counter

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: tx_data=0, tx_start=0, cmd_valid=0, cmd_code=0, cmd_arg=0, resp_ready=0, err_count=0. Parser goes to P_CMD, TX FSM to T_IDLE, ack_pending cleared.
- Reset mid-transfer: tx_start drops the next cycle; no further bytes are issued.

Parser FSM (P_CMD, P_ARG, P_CHK), advancing on rx_done:
- P_CMD latches CMD and goes to P_ARG.
- P_ARG latches ARG and goes to P_CHK.
- P_CHK compares the byte with CMD^ARG, then returns to P_CMD.
- Frame valid means checksum matches, CMD < NUM_CMDS and no parity error on any of the 3 bytes.
- Valid frame: cmd_valid pulses the cycle after the CHK rx_done (latency 1). cmd_code/cmd_arg update in that same cycle and are held until the next valid frame. ACK is queued.
- Invalid checksum or code: NACK queued, err_count+1.
- Parity error on any byte: frame discarded immediately, parser to P_CMD, NACK queued, err_count+1.
- Timeout: a counter runs in P_ARG/P_CHK and clears on every rx_done. On reaching TIMEOUT_CYC-1 the parser goes to P_CMD and err_count+1; no NACK is sent.
- ack_pending is a single entry. A new ACK/NACK arriving while one is still unsent is dropped and err_count+1; the older entry is kept.
- err_count saturates at 8'hFF.
- Simultaneous error sources in one cycle increment err_count by 1 only.

TX FSM (T_IDLE, T_START, T_WAIT):
- T_IDLE, priority 1: ack_pending has priority. Load tx_data, clear ack_pending, go to T_START.
- T_IDLE, priority 2: otherwise resp_ready=1. On resp_valid the word is latched, tx_data = resp_data[15:8], go to T_START, then send resp_data[7:0].
- resp_ready is high only in T_IDLE with ack_pending=0 and tx_busy=0.
- T_IDLE never starts a byte while tx_busy=1.
- T_START: tx_start=1 with tx_data held stable until tx_busy is seen high, then tx_start=0 and go to T_WAIT.
- T_WAIT: wait for tx_busy=0, then send the next queued byte (response LSB) or return to T_IDLE.
- A response word is never interleaved: an ACK queued between MSB and LSB waits until the LSB is done.

Decomposition:
- Shared package/header (alongside UART.vh): ACK/NACK byte values, parser and TX state encodings, frame length constant.
- One natural sub-module: uart_frame_parser (parser FSM, timeout counter, checksum). Arbitration and the TX FSM stay in uart_link_ctrl.

Test Plan:
- Valid frame: bytes 02,10,12 -> one cmd_valid pulse with cmd_code=02, cmd_arg=10; tx sends 06; err_count=0.
- Bad checksum: frame 02,10,13 -> no cmd_valid; tx sends 15; err_count=1. Out-of-range code: frame 07,00,07 -> tx sends 15; err_count=2.
- Parity error on the ARG byte, then 03,01,02 -> NACK for the first frame, ACK plus cmd_valid (03,01) for the second.
- Bytes 02,10 then idle for TIMEOUT_CYC cycles, then 04,05,01 -> no NACK; err_count=1; cmd_valid with 04/05.
- resp_valid with resp_data=16'hABCD while a frame completes mid-MSB -> tx order AB, CD, then 06; resp_ready low throughout.
- Assert reset during T_START -> tx_start=0 the next cycle; all outputs at reset values; the next frame is processed normally.
